// File: rtl/byte_mem_responder.sv
// Byte-wide memory responder: RAM plus optional IO region (TX FIFO, halt) under MEMRSP_IO_EN.
// Latency: mem_din is registered, valid one cycle after the address; FIFO flags are registered.
// Backpressure: rdy=0 freezes all state; TX FIFO drains on io_tx_valid&&io_tx_ready, drops pushes when full.
module byte_mem_responder #(
    parameter int ADDR_WIDTH  = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  io_tx_data,
    output logic        io_tx_valid,
    input  logic        io_tx_ready,
    output logic        io_overflow,
    output logic        sim_halt
);
    logic [7:0]            ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  is_io;
    logic [7:0]            io_rd_dat;

    assign ram_addr = mem_a[ADDR_WIDTH-1:0];

    // RAM contents are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (rdy && mem_wr && !is_io)
            ram[ram_addr] <= mem_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_din <= '0;
        else if (rdy) begin
            if (mem_wr)
                mem_din <= '0;
            else if (is_io)
                mem_din <= io_rd_dat;
            else
                mem_din <= ram[ram_addr];
        end
    end

`ifdef MEMRSP_IO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_n;
    logic             tx_sel, halt_sel, fifo_full, push, pop, push_ok;
    logic             unused_in;

    assign unused_in = ^mem_a[31:ADDR_WIDTH];
    assign is_io     = (mem_a[17:16] == 2'b11);
    assign tx_sel    = is_io && (mem_a[15:0] == 16'h0000);
    assign halt_sel  = is_io && (mem_a[15:0] == 16'h0004);
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = rdy && io_tx_valid && io_tx_ready;
    assign push      = rdy && mem_wr && tx_sel;
    // A pop in the same cycle frees the slot, so a push at full still lands
    assign push_ok   = push && (!fifo_full || pop);

    always_comb begin
        count_n = count;
        case ({push_ok, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= mem_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            io_overflow    <= 1'b0;
            sim_halt       <= 1'b0;
        end else begin
            sim_halt <= rdy && mem_wr && halt_sel;
            if (rdy) begin
                count          <= count_n;
                io_buffer_full <= (count_n >= CNT_W'(FIFO_DEPTH - FULL_MARGIN));
                if (push_ok)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !push_ok)
                    io_overflow <= 1'b1;
            end
        end
    end

    assign io_tx_valid = (count != '0);
    assign io_tx_data  = io_tx_valid ? fifo_mem[rd_ptr] : 8'h00;

    always_comb begin
        io_rd_dat = '0;
        if (tx_sel)
            io_rd_dat = {7'b0, io_tx_valid};
        else if (halt_sel)
            io_rd_dat[CNT_W-1:0] = count;
    end
`else
    logic unused_in;

    assign unused_in      = ^{mem_a[31:ADDR_WIDTH], io_tx_ready};
    assign is_io          = 1'b0;
    assign io_rd_dat      = '0;
    assign io_buffer_full = 1'b0;
    assign io_tx_data     = '0;
    assign io_tx_valid    = 1'b0;
    assign io_overflow    = 1'b0;
    assign sim_halt       = 1'b0;
`endif

endmodule

// File: tb/tb_byte_mem_responder.sv
// Bench for byte_mem_responder: vector table, directed FIFO/halt/reset sequences, random traffic vs queue model.
`timescale 1ns/1ps
module tb_byte_mem_responder;
`ifdef MEMRSP_IO_EN
    localparam bit IO_ON = 1'b1;
`else
    localparam bit IO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] mem_a = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = '0;
    logic        io_tx_ready = 1'b0;
    logic [7:0]  mem_din, io_tx_data;
    logic        io_buffer_full, io_tx_valid, io_overflow, sim_halt;

    always #5 clk = ~clk;

    byte_mem_responder dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .io_tx_data(io_tx_data), .io_tx_valid(io_tx_valid), .io_tx_ready(io_tx_ready),
        .io_overflow(io_overflow), .sim_halt(sim_halt)
    );

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [7:0]  d;
        logic [7:0]  exp_din;
    } vec_t;

    int total = 0;
    int bad = 0;

    // Reference model: sparse RAM image and TX FIFO as a queue
    logic [7:0] ref_ram [int];
    logic [7:0] q[$];
    logic       m_ovf, m_full, m_halt, din_ok;
    logic [7:0] m_din;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf = 1'b0; m_full = 1'b0; m_halt = 1'b0; m_din = 8'h00; din_ok = 1'b1;
    endtask

    task automatic cyc(input logic [31:0] a, input logic w, input logic [7:0] d,
                       input logic r, input logic txr, input string nm);
        logic        io, pop, push;
        logic [16:0] ra;
        int          pre;
        io  = IO_ON && (a[17:16] == 2'b11);
        ra  = a[16:0];
        pre = q.size();
        if (r) begin
            if (w) begin
                m_din = 8'h00; din_ok = 1'b1;
            end else if (io) begin
                m_din  = (a[15:0] == 16'h0) ? 8'(pre != 0) : (a[15:0] == 16'h4) ? 8'(pre) : 8'h00;
                din_ok = 1'b1;
            end else begin
                din_ok = ref_ram.exists(int'(ra));
                m_din  = din_ok ? ref_ram[int'(ra)] : 8'h00;
            end
            if (w && !io) ref_ram[int'(ra)] = d;
            pop  = IO_ON && (pre > 0) && txr;
            push = io && w && (a[15:0] == 16'h0);
            if (pop) void'(q.pop_front());
            if (push) begin
                if (pre < 8 || pop) q.push_back(d);
                else m_ovf = 1'b1;
            end
            m_full = (q.size() >= 6);
            m_halt = io && w && (a[15:0] == 16'h4);
        end else begin
            m_halt = 1'b0;
        end
        mem_a = a; mem_wr = w; mem_dout = d; rdy = r; io_tx_ready = txr;
        @(posedge clk); #1;
        if (din_ok) chk({nm, " din"}, 32'(mem_din), 32'(m_din));
        chk({nm, " vld"},  32'(io_tx_valid),    32'(q.size() > 0));
        chk({nm, " dat"},  32'(io_tx_data),     32'(q.size() > 0 ? q[0] : 8'h00));
        chk({nm, " full"}, 32'(io_buffer_full), 32'(m_full));
        chk({nm, " ovf"},  32'(io_overflow),    32'(m_ovf));
        chk({nm, " halt"}, 32'(sim_halt),       32'(m_halt));
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " din"},  32'(mem_din), 0);
        chk({nm, " full"}, 32'(io_buffer_full), 0);
        chk({nm, " vld"},  32'(io_tx_valid), 0);
        chk({nm, " dat"},  32'(io_tx_data), 0);
        chk({nm, " ovf"},  32'(io_overflow), 0);
        chk({nm, " halt"}, 32'(sim_halt), 0);
    endtask

    vec_t tv [13];

    initial begin
        tv = '{
            '{32'h0000_0010, 1'b1, 8'hA5, 8'h00},
            '{32'h0000_0010, 1'b0, 8'h00, 8'hA5},
            '{32'h0000_0100, 1'b1, 8'h78, 8'h00},
            '{32'h0000_0101, 1'b1, 8'h56, 8'h00},
            '{32'h0000_0102, 1'b1, 8'h34, 8'h00},
            '{32'h0000_0103, 1'b1, 8'h12, 8'h00},
            '{32'h0000_0100, 1'b0, 8'h00, 8'h78},
            '{32'h0000_0101, 1'b0, 8'h00, 8'h56},
            '{32'h0000_0102, 1'b0, 8'h00, 8'h34},
            '{32'h0000_0103, 1'b0, 8'h00, 8'h12},
            '{32'h0000_0010, 1'b0, 8'h00, 8'hA5},
            '{32'h0000_0011, 1'b1, 8'hC3, 8'h00},
            '{32'h0000_0011, 1'b0, 8'h00, 8'hC3}
        };
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(tv[i].a, tv[i].w, tv[i].d, 1'b1, 1'b0, "tbl");
            chk("tbl exp din", 32'(mem_din), 32'(tv[i].exp_din));
        end

        // rdy=0 must block the write and hold mem_din
        cyc(32'h20, 1'b1, 8'h11, 1'b1, 1'b0, "t5 wr");
        cyc(32'h20, 1'b0, 8'h00, 1'b1, 1'b0, "t5 rd");
        cyc(32'h20, 1'b1, 8'hFF, 1'b0, 1'b0, "t5 hold");
        cyc(32'h30, 1'b0, 8'h00, 1'b0, 1'b0, "t5 hold2");
        chk("t5 din held", 32'(mem_din), 32'h11);
        cyc(32'h20, 1'b0, 8'h00, 1'b1, 1'b0, "t5 rd2");
        chk("t5 ram kept", 32'(mem_din), 32'h11);

`ifdef MEMRSP_IO_EN
        for (int k = 1; k <= 9; k++) cyc(32'h30000, 1'b1, 8'(k), 1'b1, 1'b0, "t3 push");
        chk("t3 ovf set", 32'(io_overflow), 1);
        cyc(32'h30004, 1'b0, 8'h00, 1'b1, 1'b0, "t3 cnt");
        chk("t3 cnt8", 32'(mem_din), 8);
        for (int k = 1; k <= 8; k++) begin
            chk("t3 drain", 32'(io_tx_data), k);
            cyc(32'h10, 1'b0, 8'h00, 1'b1, 1'b1, "t3 pop");
        end
        chk("t3 empty", 32'(io_tx_valid), 0);

        for (int k = 1; k <= 3; k++) cyc(32'h30000, 1'b1, 8'(8'h40 + k), 1'b1, 1'b0, "t4 fill");
        cyc(32'h30000, 1'b1, 8'hAA, 1'b1, 1'b1, "t4 pushpop");
        cyc(32'h30004, 1'b0, 8'h00, 1'b1, 1'b0, "t4 cnt");
        chk("t4 cnt3", 32'(mem_din), 3);
        cyc(32'h30000, 1'b0, 8'h00, 1'b1, 1'b0, "t4 stat");
        chk("t4 stat vld", 32'(mem_din), 1);

        cyc(32'h30004, 1'b1, 8'h77, 1'b1, 1'b0, "halt wr");
        chk("halt pulse", 32'(sim_halt), 1);
        cyc(32'h10, 1'b0, 8'h00, 1'b1, 1'b0, "halt off");
        chk("halt clear", 32'(sim_halt), 0);
`else
        cyc(32'h30000, 1'b1, 8'h5A, 1'b1, 1'b0, "t6 wr");
        chk("t6 no halt", 32'(sim_halt), 0);
        cyc(32'h10000, 1'b0, 8'h00, 1'b1, 1'b0, "t6 rd");
        chk("t6 alias", 32'(mem_din), 32'h5A);
`endif

        for (int i = 0; i < 256; i++)
            cyc(32'h200 + 32'(i), 1'b1, 8'($urandom), 1'b1, 1'b0, "rnd init");
        for (int i = 0; i < 800; i++) begin
            int          kind;
            logic [31:0] a;
            logic        w, r, txr;
            kind = $urandom_range(0, 9);
            w    = 1'($urandom_range(0, 1));
            r    = ($urandom_range(0, 9) != 0);
            txr  = 1'($urandom_range(0, 1));
            a    = $urandom();
            a[16:0] = 17'h200 + 17'($urandom_range(0, 255));
            case (kind)
                6: begin a = 32'h30000; w = 1'b1; end
                7: begin a = $urandom_range(0, 1) ? 32'h30000 : 32'h30004; w = 1'b0; end
                8: begin a = 32'h30004; w = 1'b1; end
                9: a = 32'h30008;
                default: ;
            endcase
            cyc(a, w, 8'($urandom), r, txr, "rnd");
        end

        // Asynchronous reset mid-stream with non-zero outputs
        cyc(32'h30000, 1'b1, 8'h9C, 1'b1, 1'b0, "t5 pre push");
        cyc(32'h10, 1'b0, 8'h00, 1'b1, 1'b0, "t5 pre rd");
        #2 rst_n = 1'b0;
        #1;
        check_zero("arst");
        model_clear();
        rst_n = 1'b1;
        cyc(32'h10, 1'b0, 8'h00, 1'b1, 1'b1, "post rst");
        chk("post rst ram", 32'(mem_din), 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
